// File: rtl/deserializer.sv
// Serial-to-parallel receive stage: recovers start/data/parity/stop frames from io_sIn
// and presents good packets on a valid/ready parallel port with error pulses.
module deserializer #(
    parameter int PKT_W     = 4,
    parameter int PARITY_EN = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_sIn,
    output logic [PKT_W-1:0] io_pOut,
    output logic             io_validOut,
    input  logic             io_readyOut,
    output logic             io_frameErr,
    output logic             io_parityErr,
    output logic             io_overflow,
    output logic             io_busy
);

    localparam int CNT_W = (PKT_W > 2) ? $clog2(PKT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_RESYNC
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PKT_W-1:0] shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [PKT_W-1:0] pout_q, pout_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             ovf_q, ovf_d;
    logic             parity_bad;

    // Even parity over data plus parity bit; a set XOR means a flipped bit.
    assign parity_bad = (PARITY_EN != 0) && ((^shift_q) ^ parity_q);

    always_comb begin
        // NOTE: every next-state variable gets a default here so no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pout_d   = pout_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        ferr_d   = 1'b0;
        perr_d   = 1'b0;

        if (valid_q && io_readyOut) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (io_sIn) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (MSB_FIRST != 0) begin
                    shift_d = {shift_q[PKT_W-2:0], io_sIn};
                end else begin
                    shift_d = {io_sIn, shift_q[PKT_W-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                parity_d = io_sIn;
                state_d  = S_STOP;
            end
            S_STOP: begin
                state_d = io_sIn ? S_RESYNC : S_IDLE;
                if (io_sIn) begin
                    ferr_d = 1'b1;
                end else if (parity_bad) begin
                    perr_d = 1'b1;
                end else if (!valid_q || io_readyOut) begin
                    // A slot freed by this cycle's transfer is reused on the same edge.
                    pout_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            S_RESYNC: begin
                if (!io_sIn) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            pout_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            pout_q   <= pout_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            ovf_q    <= ovf_d;
        end
    end

    assign io_pOut      = pout_q;
    assign io_validOut  = valid_q;
    assign io_frameErr  = ferr_q;
    assign io_parityErr = perr_q;
    assign io_overflow  = ovf_q;
    assign io_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer (PKT_W=4, even parity, MSB first): a vector table for
// reset/single/back-to-back/error frames, then hand sequences for backpressure and mid-frame reset.
module tb_deserializer;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_sIn;
    logic       io_readyOut;
    logic [3:0] io_pOut;
    logic       io_validOut;
    logic       io_frameErr;
    logic       io_parityErr;
    logic       io_overflow;
    logic       io_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    deserializer #(
        .PKT_W    (4),
        .PARITY_EN(1),
        .MSB_FIRST(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_sIn      (io_sIn),
        .io_pOut     (io_pOut),
        .io_validOut (io_validOut),
        .io_readyOut (io_readyOut),
        .io_frameErr (io_frameErr),
        .io_parityErr(io_parityErr),
        .io_overflow (io_overflow),
        .io_busy     (io_busy)
    );

    typedef struct {
        bit       rst_n;
        bit       sin;
        bit       rdy;
        bit       chk_p;
        logic [3:0] p;
        bit       v;
        bit       fe;
        bit       pe;
        bit       ov;
        bit       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst_n, bit sin, bit rdy, bit chk_p, logic [3:0] p,
                                bit v, bit fe, bit pe, bit ov, bit busy);
        vec_t x;
        x.rst_n = rst_n; x.sin = sin; x.rdy = rdy; x.chk_p = chk_p; x.p = p;
        x.v = v; x.fe = fe; x.pe = pe; x.ov = ov; x.busy = busy;
        vecs.push_back(x);
    endfunction

    // First six bits of a frame (start, data, parity): FSM busy, nothing presented.
    function automatic void add_body(logic [5:0] bits);
        logic [5:0] b;
        b = bits;
        for (int i = 5; i >= 0; i--) add(1, b[i], 1, 0, 4'h0, 0, 0, 0, 0, 1);
    endfunction

    // Output bundle {pOut, valid, frameErr, parityErr, overflow, busy}; pOut masked when chk_p=0.
    task automatic check_out(string name, bit chk_p, logic [3:0] p,
                             bit v, bit fe, bit pe, bit ov, bit busy);
        logic [8:0] act;
        logic [8:0] exp;
        act = {chk_p ? io_pOut : 4'h0, io_validOut, io_frameErr, io_parityErr, io_overflow, io_busy};
        exp = {chk_p ? p : 4'h0, v, fe, pe, ov, busy};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got pOut/v/fe/pe/ov/busy=%h/%b%b%b%b%b want %h/%b%b%b%b%b",
                     name, act[8:5], act[4], act[3], act[2], act[1], act[0],
                     exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic tick(bit rst_n, bit sin, bit rdy);
        @(negedge clock);
        reset       = rst_n;
        io_sIn      = sin;
        io_readyOut = rdy;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [6:0] fa;
        logic [6:0] ff;
        logic [6:0] f5;

        reset = 1'b0; io_sIn = 1'b0; io_readyOut = 1'b1;
        fa = 7'b1101000;
        ff = 7'b1111100;
        f5 = 7'b1010100;

        // reset held 2 cycles with sIn=1, then idle
        add(0, 1, 1, 1, 4'h0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 4'h0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 4'h0, 0, 0, 0, 0, 0);
        // single 0xA: valid for exactly one cycle
        add_body(6'b110100);
        add(1, 0, 1, 1, 4'hA, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0);
        // back-to-back 0xA then 0xF
        add_body(6'b110100);
        add(1, 0, 1, 1, 4'hA, 1, 0, 0, 0, 0);
        add_body(6'b111110);
        add(1, 0, 1, 1, 4'hF, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0);
        // parity error
        add_body(6'b110101);
        add(1, 0, 1, 0, 4'h0, 0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0);
        // frame error, resync through 1,1,0, then clean 0x5
        add_body(6'b110100);
        add(1, 1, 1, 0, 4'h0, 0, 1, 0, 0, 1);
        add(1, 1, 1, 0, 4'h0, 0, 0, 0, 0, 1);
        add(1, 1, 1, 0, 4'h0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0);
        add_body(6'b101010);
        add(1, 0, 1, 1, 4'h5, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].rst_n, vecs[i].sin, vecs[i].rdy);
            check_out($sformatf("vec%0d", i), vecs[i].chk_p, vecs[i].p, vecs[i].v,
                      vecs[i].fe, vecs[i].pe, vecs[i].ov, vecs[i].busy);
        end

        // backpressure: 0xA held, 0xF dropped with sticky overflow
        tick(0, 0, 0);
        check_out("bp_reset", 1, 4'h0, 0, 0, 0, 0, 0);
        for (int i = 6; i >= 0; i--) tick(1, fa[i], 0);
        check_out("bp_a_valid", 1, 4'hA, 1, 0, 0, 0, 0);
        for (int i = 6; i >= 1; i--) begin
            tick(1, ff[i], 0);
            check_out($sformatf("bp_hold%0d", i), 1, 4'hA, 1, 0, 0, 0, 1);
        end
        tick(1, ff[0], 0);
        check_out("bp_overflow", 1, 4'hA, 1, 0, 0, 1, 0);
        tick(1, 0, 0);
        check_out("bp_still_held", 1, 4'hA, 1, 0, 0, 1, 0);
        tick(1, 0, 1);
        check_out("bp_consumed", 0, 4'h0, 0, 0, 0, 1, 0);
        tick(1, 0, 0);
        check_out("bp_ovf_sticky", 0, 4'h0, 0, 0, 0, 1, 0);

        // ready in the stop cycle of the second frame: 0xF replaces 0xA, no overflow
        tick(0, 0, 0);
        check_out("bp2_reset", 1, 4'h0, 0, 0, 0, 0, 0);
        tick(1, 0, 0);
        for (int i = 6; i >= 0; i--) tick(1, fa[i], 0);
        check_out("bp2_a_valid", 1, 4'hA, 1, 0, 0, 0, 0);
        for (int i = 6; i >= 1; i--) tick(1, ff[i], 0);
        check_out("bp2_a_held", 1, 4'hA, 1, 0, 0, 0, 1);
        tick(1, ff[0], 1);
        check_out("bp2_f_loaded", 1, 4'hF, 1, 0, 0, 0, 0);
        tick(1, 0, 1);
        check_out("bp2_f_consumed", 0, 4'h0, 0, 0, 0, 0, 0);

        // mid-frame reset discards partial 0xA; next 0x5 is received
        tick(1, 1, 1);
        tick(1, 1, 1);
        tick(1, 0, 1);
        check_out("mr_busy", 0, 4'h0, 0, 0, 0, 0, 1);
        tick(0, 1, 1);
        check_out("mr_reset", 1, 4'h0, 0, 0, 0, 0, 0);
        tick(1, 0, 1);
        check_out("mr_idle", 1, 4'h0, 0, 0, 0, 0, 0);
        for (int i = 6; i >= 1; i--) begin
            tick(1, f5[i], 1);
            check_out($sformatf("mr_body%0d", i), 0, 4'h0, 0, 0, 0, 0, 1);
        end
        tick(1, f5[0], 1);
        check_out("mr_pkt5", 1, 4'h5, 1, 0, 0, 0, 0);
        tick(1, 0, 1);
        check_out("mr_done", 0, 4'h0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
